// File: rtl/tnoc_packet_packer_if.sv
// Bus bundle for the packet packer.
//   header_*  : packed multi-flit header offered by the upstream packet source
//   payload_* : payload word stream that follows a header with payload
//   flit_*    : serialised flit stream towards the NoC router
// slave  = packer side, master = environment (source + downstream sink) side.
interface tnoc_packet_packer_if #(
  parameter int FLIT_DATA_WIDTH      = 64,
  parameter int REQUEST_HEADER_FLITS = 2
);
  logic                                            header_valid;
  logic                                            header_ready;
  logic [REQUEST_HEADER_FLITS*FLIT_DATA_WIDTH-1:0] header_data;
  logic                                            header_is_request;
  logic                                            header_has_payload;
  logic                                            payload_valid;
  logic                                            payload_ready;
  logic [FLIT_DATA_WIDTH-1:0]                      payload_data;
  logic                                            payload_last;
  logic                                            flit_valid;
  logic                                            flit_ready;
  logic                                            flit_type;
  logic                                            flit_head;
  logic                                            flit_tail;
  logic [FLIT_DATA_WIDTH-1:0]                      flit_data;

  modport slave (
    input  header_valid, header_data, header_is_request, header_has_payload,
    output header_ready,
    input  payload_valid, payload_data, payload_last,
    output payload_ready,
    output flit_valid, flit_type, flit_head, flit_tail, flit_data,
    input  flit_ready
  );

  modport master (
    output header_valid, header_data, header_is_request, header_has_payload,
    input  header_ready,
    output payload_valid, payload_data, payload_last,
    input  payload_ready,
    input  flit_valid, flit_type, flit_head, flit_tail, flit_data,
    output flit_ready
  );
endinterface

// File: rtl/tnoc_packet_packer.sv
// Packet packer: serialises a packed header (request or response length) and an
// optional payload word stream into a single flit stream, zero-latency, one
// flit per cycle.
// Ports:
//   clk  : sole clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : tnoc_packet_packer_if.slave (header/payload in, flits out)
//
// state   | meaning
// HEADER  | emitting header flit flit_count of the offered header
// PAYLOAD | forwarding payload words until payload_last is accepted
module tnoc_packet_packer #(
  parameter int FLIT_DATA_WIDTH       = 64,
  parameter int REQUEST_HEADER_FLITS  = 2,
  parameter int RESPONSE_HEADER_FLITS = 1
) (
  input logic                        clk,
  input logic                        rst,
  tnoc_packet_packer_if.slave        bus
);

  localparam int CW = (REQUEST_HEADER_FLITS > 1) ? $clog2(REQUEST_HEADER_FLITS) : 1;
  localparam logic [CW-1:0] REQ_LAST = CW'(REQUEST_HEADER_FLITS - 1);
  localparam logic [CW-1:0] RSP_LAST = CW'(RESPONSE_HEADER_FLITS - 1);

  typedef enum logic {
    ST_HEADER  = 1'b0,
    ST_PAYLOAD = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  flit_count_q, flit_count_d;
  logic [CW-1:0]  last_count;
  logic           header_last;
  logic           handshake;
  logic           flit_valid_raw;

  logic [FLIT_DATA_WIDTH-1:0] header_flits [REQUEST_HEADER_FLITS];

  for (genvar k = 0; k < REQUEST_HEADER_FLITS; k++) begin : g_slice
    assign header_flits[k] = bus.header_data[k*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH];
  end

  always_comb begin
    state_d            = state_q;
    flit_count_d       = flit_count_q;
    last_count         = bus.header_is_request ? REQ_LAST : RSP_LAST;
    header_last        = (flit_count_q == last_count);
    flit_valid_raw     = 1'b0;
    bus.flit_type      = 1'b0;
    bus.flit_head      = 1'b0;
    bus.flit_tail      = 1'b0;
    bus.flit_data      = '0;
    bus.header_ready   = 1'b0;
    bus.payload_ready  = 1'b0;

    case (state_q)
      ST_HEADER: begin
        flit_valid_raw   = bus.header_valid;
        bus.flit_data    = header_flits[flit_count_q];
        bus.flit_head    = (flit_count_q == '0);
        bus.flit_tail    = header_last & ~bus.header_has_payload;
        bus.header_ready = bus.flit_ready & header_last;
      end
      default: begin
        flit_valid_raw    = bus.payload_valid;
        bus.flit_type     = 1'b1;
        bus.flit_data     = bus.payload_data;
        bus.flit_tail     = bus.payload_last;
        bus.payload_ready = bus.flit_ready;
      end
    endcase

    handshake = flit_valid_raw & bus.flit_ready;

    if (handshake) begin
      if (state_q == ST_HEADER) begin
        if (header_last) begin
          flit_count_d = '0;
          state_d      = bus.header_has_payload ? ST_PAYLOAD : ST_HEADER;
        end else begin
          flit_count_d = flit_count_q + 1'b1;
        end
      end else if (bus.payload_last) begin
        state_d = ST_HEADER;
      end
    end

    // Reset must silence the handshake outputs even while inputs are active.
    bus.flit_valid = flit_valid_raw & ~rst;
    if (rst) begin
      bus.header_ready  = 1'b0;
      bus.payload_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_HEADER;
      flit_count_q <= '0;
    end else begin
      state_q      <= state_d;
      flit_count_q <= flit_count_d;
    end
  end

endmodule

// File: tb/tb_tnoc_packet_packer.sv
module tb_tnoc_packet_packer;

  localparam int W   = 64;
  localparam int REQ = 2;
  localparam int RSP = 1;

  typedef struct {
    logic [REQ*W-1:0] data;
    logic             is_req;
    logic             has_pl;
  } hdr_t;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } pl_t;

  typedef struct {
    logic         ftype;
    logic         head;
    logic         tail;
    logic [W-1:0] data;
    logic         hr;
    logic         pr;
  } flit_t;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   h_took, p_took;

  hdr_t  hdr_q[$];
  pl_t   pl_q[$];
  flit_t exp_q[$];
  int    hs_cyc[$];

  tnoc_packet_packer_if #(.FLIT_DATA_WIDTH(W), .REQUEST_HEADER_FLITS(REQ)) bus ();

  tnoc_packet_packer #(
    .FLIT_DATA_WIDTH(W),
    .REQUEST_HEADER_FLITS(REQ),
    .RESPONSE_HEADER_FLITS(RSP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: a packet is its header flits followed by its payload words.
  task automatic enqueue_pkt(input bit is_req, input bit has_pl, input logic [W-1:0] h0,
                             input logic [W-1:0] h1, input int n, input logic [W-1:0] base);
    hdr_t  h;
    pl_t   p;
    flit_t f;
    int    nh;
    nh = is_req ? REQ : RSP;
    h.data = {h1, h0};
    h.is_req = is_req;
    h.has_pl = has_pl;
    hdr_q.push_back(h);
    for (int k = 0; k < nh; k++) begin
      f.ftype = 1'b0;
      f.head  = (k == 0);
      f.tail  = (k == nh - 1) && !has_pl;
      f.data  = (k == 0) ? h0 : h1;
      f.hr    = (k == nh - 1);
      f.pr    = 1'b0;
      exp_q.push_back(f);
    end
    if (has_pl) begin
      for (int i = 0; i < n; i++) begin
        p.data = base + W'(i);
        p.last = (i == n - 1);
        pl_q.push_back(p);
        f.ftype = 1'b1;
        f.head  = 1'b0;
        f.tail  = (i == n - 1);
        f.data  = base + W'(i);
        f.hr    = 1'b0;
        f.pr    = 1'b1;
        exp_q.push_back(f);
      end
    end
  endtask

  // Header source
  always begin
    @(negedge clk);
    h_took = bus.header_valid && bus.header_ready;
    @(posedge clk);
    #1;
    if (h_took && hdr_q.size() > 0) void'(hdr_q.pop_front());
    if (hdr_q.size() > 0) begin
      bus.header_valid       = 1'b1;
      bus.header_data        = hdr_q[0].data;
      bus.header_is_request  = hdr_q[0].is_req;
      bus.header_has_payload = hdr_q[0].has_pl;
    end else begin
      bus.header_valid = 1'b0;
    end
  end

  // Payload source
  always begin
    @(negedge clk);
    p_took = bus.payload_valid && bus.payload_ready;
    @(posedge clk);
    #1;
    if (p_took && pl_q.size() > 0) void'(pl_q.pop_front());
    if (pl_q.size() > 0) begin
      bus.payload_valid = 1'b1;
      bus.payload_data  = pl_q[0].data;
      bus.payload_last  = pl_q[0].last;
    end else begin
      bus.payload_valid = 1'b0;
    end
  end

  // Compare every accepted flit against the model stream.
  always @(negedge clk) begin
    if (!rst && bus.flit_valid && bus.flit_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_flit", 64'd1, 64'd0);
      end else begin
        check("flit_type", 64'(bus.flit_type), 64'(exp_q[0].ftype));
        check("flit_head", 64'(bus.flit_head), 64'(exp_q[0].head));
        check("flit_tail", 64'(bus.flit_tail), 64'(exp_q[0].tail));
        check("flit_data", bus.flit_data, exp_q[0].data);
        check("header_ready", 64'(bus.header_ready), 64'(exp_q[0].hr));
        check("payload_ready", 64'(bus.payload_ready), 64'(exp_q[0].pr));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((hdr_q.size() != 0 || pl_q.size() != 0 || exp_q.size() != 0) && n < 200) begin
      step();
      n++;
    end
    check({name, "_drain_timeout"}, 64'(n >= 200), 64'd0);
    step();
  endtask

  task automatic check_back_to_back(input string name, input int nflits);
    check({name, "_flit_count"}, 64'(hs_cyc.size()), 64'(nflits));
    for (int i = 1; i < hs_cyc.size(); i++)
      check({name, "_no_bubble"}, 64'(hs_cyc[i] - hs_cyc[i-1]), 64'd1);
  endtask

  initial begin
    rst                    = 1'b1;
    bus.header_valid       = 1'b0;
    bus.header_data        = '0;
    bus.header_is_request  = 1'b0;
    bus.header_has_payload = 1'b0;
    bus.payload_valid      = 1'b0;
    bus.payload_data       = '0;
    bus.payload_last       = 1'b0;
    bus.flit_ready         = 1'b1;

    // Reset state
    repeat (2) step();
    @(negedge clk);
    check("rst_flit_valid", 64'(bus.flit_valid), 64'd0);
    check("rst_header_ready", 64'(bus.header_ready), 64'd0);
    check("rst_payload_ready", 64'(bus.payload_ready), 64'd0);
    check("rst_flit_count", 64'(dut.flit_count_q), 64'd0);
    step();
    rst = 1'b0;
    step();

    // Request with 3 payload words at full rate; pin the model first.
    enqueue_pkt(1'b1, 1'b1, 64'hA000_0000_0000_0000, 64'hA111_1111_1111_1111, 3, 64'hD000_0000_0000_0010);
    check("model_len", 64'(exp_q.size()), 64'd5);
    check("model_types", 64'({exp_q[0].ftype, exp_q[1].ftype, exp_q[2].ftype, exp_q[3].ftype, exp_q[4].ftype}), 64'b00111);
    check("model_heads", 64'({exp_q[0].head, exp_q[1].head, exp_q[2].head, exp_q[3].head, exp_q[4].head}), 64'b10000);
    check("model_tails", 64'({exp_q[0].tail, exp_q[1].tail, exp_q[2].tail, exp_q[3].tail, exp_q[4].tail}), 64'b00001);
    check("model_hready", 64'({exp_q[0].hr, exp_q[1].hr, exp_q[2].hr, exp_q[3].hr, exp_q[4].hr}), 64'b01000);
    check("model_last_data", exp_q[4].data, 64'hD000_0000_0000_0012);
    hs_cyc.delete();
    wait_drain("req_pl");
    check_back_to_back("req_pl", 5);

    // Two single-flit responses back to back.
    hs_cyc.delete();
    enqueue_pkt(1'b0, 1'b0, 64'hB000_0000_0000_0001, 64'h0, 0, 64'h0);
    enqueue_pkt(1'b0, 1'b0, 64'hB000_0000_0000_0002, 64'h0, 0, 64'h0);
    check("model_single_head_tail", 64'({exp_q[0].head, exp_q[0].tail, exp_q[0].hr}), 64'b111);
    wait_drain("rsp_single");
    check_back_to_back("rsp_single", 2);

    // Mixed back-to-back packets.
    hs_cyc.delete();
    enqueue_pkt(1'b1, 1'b1, 64'hC000_0000_0000_0000, 64'hC111_1111_1111_1111, 2, 64'hE000_0000_0000_0000);
    enqueue_pkt(1'b0, 1'b0, 64'hC222_2222_2222_2222, 64'h0, 0, 64'h0);
    enqueue_pkt(1'b1, 1'b0, 64'hC333_3333_3333_3333, 64'hC444_4444_4444_4444, 0, 64'h0);
    wait_drain("b2b");
    check_back_to_back("b2b", 7);

    // Stall on H1 with payload already offered.
    bus.flit_ready = 1'b0;
    enqueue_pkt(1'b1, 1'b1, 64'h1111_0000_0000_0000, 64'h2222_0000_0000_0000, 1, 64'hF000_0000_0000_0000);
    step();
    bus.flit_ready = 1'b1;
    step();
    bus.flit_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 64'(bus.flit_valid), 64'd1);
      check("stall_data", bus.flit_data, 64'h2222_0000_0000_0000);
      check("stall_count", 64'(dut.flit_count_q), 64'd1);
      check("stall_hready", 64'(bus.header_ready), 64'd0);
      check("stall_pready", 64'(bus.payload_ready & bus.payload_valid), 64'd0);
      step();
    end
    bus.flit_ready = 1'b1;
    wait_drain("stall");

    // Reset after the H0 handshake abandons the packet.
    bus.flit_ready = 1'b0;
    enqueue_pkt(1'b1, 1'b1, 64'h5555_0000_0000_0000, 64'h6666_0000_0000_0000, 2, 64'h7000_0000_0000_0000);
    step();
    bus.flit_ready = 1'b1;
    step();
    rst = 1'b1;
    @(negedge clk);
    check("midrst_header_valid_in", 64'(bus.header_valid), 64'd1);
    check("midrst_flit_valid", 64'(bus.flit_valid), 64'd0);
    check("midrst_header_ready", 64'(bus.header_ready), 64'd0);
    check("midrst_payload_ready", 64'(bus.payload_ready), 64'd0);
    step();
    exp_q.delete();
    pl_q.delete();
    hdr_q.delete();
    enqueue_pkt(1'b1, 1'b1, 64'h5555_0000_0000_0000, 64'h6666_0000_0000_0000, 2, 64'h7000_0000_0000_0000);
    rst = 1'b0;
    @(negedge clk);
    check("postrst_head", 64'(bus.flit_head), 64'd1);
    check("postrst_data", bus.flit_data, 64'h5555_0000_0000_0000);
    wait_drain("postrst");

    check("leftover_expected", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tnoc_packet_packer.md
TNOC_PACKET_PACKER -- requirements
Module: tnoc_packet_packer

Interface
REQ-001 Parameter FLIT_DATA_WIDTH, default 64, SHALL set the width of every flit and payload data word.
REQ-002 Parameter REQUEST_HEADER_FLITS, default 2, SHALL set the header flit count for request packets (range 1..4).
REQ-003 Parameter RESPONSE_HEADER_FLITS, default 1, SHALL set the header flit count for response packets (range 1..REQUEST_HEADER_FLITS).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  in  1  sole clock, all state on rising edge.
REQ-006 rst  in  1  asynchronous active-high reset.
REQ-007 header_valid  in  1  packet header offered.
REQ-008 header_ready  out  1  header consumed (pulses on last header flit handshake).
REQ-009 header_data  in  REQUEST_HEADER_FLITS*FLIT_DATA_WIDTH  packed header; flit k = bits [k*FLIT_DATA_WIDTH +: FLIT_DATA_WIDTH].
REQ-010 header_is_request  in  1  1 = request header length, 0 = response header length.
REQ-011 header_has_payload  in  1  1 = payload flits follow the header.
REQ-012 payload_valid  in  1  payload word offered.
REQ-013 payload_ready  out  1  payload word consumed.
REQ-014 payload_data  in  FLIT_DATA_WIDTH  payload word.
REQ-015 payload_last  in  1  final payload word of the packet.
REQ-016 flit_valid  out  1  flit offered downstream.
REQ-017 flit_ready  in  1  downstream accepts flit.
REQ-018 flit_type  out  1  0 = header flit, 1 = payload flit.
REQ-019 flit_head  out  1  first flit of packet.
REQ-020 flit_tail  out  1  last flit of packet.
REQ-021 flit_data  out  FLIT_DATA_WIDTH  flit payload.

Function
REQ-022 FSM states SHALL be HEADER and PAYLOAD, plus header flit counter flit_count (width clog2(REQUEST_HEADER_FLITS), min 1).
REQ-023 last_count SHALL be REQUEST_HEADER_FLITS-1 if header_is_request else RESPONSE_HEADER_FLITS-1; header_last = (flit_count == last_count).
REQ-024 In HEADER: flit_valid = header_valid; flit_type = 0; flit_data = header slice flit_count; flit_head = (flit_count==0); flit_tail = header_last & !header_has_payload.
REQ-025 In HEADER: header_ready = flit_ready & header_last; payload_ready = 0.
REQ-026 HEADER handshake (flit_valid & flit_ready), not header_last: flit_count += 1, state unchanged.
REQ-027 HEADER handshake with header_last: flit_count <= 0; state <= PAYLOAD if header_has_payload else HEADER.
REQ-028 In PAYLOAD: flit_valid = payload_valid; flit_type = 1; flit_data = payload_data; flit_head = 0; flit_tail = payload_last; payload_ready = flit_ready; header_ready = 0.
REQ-029 PAYLOAD handshake with payload_last SHALL return state to HEADER; without it state unchanged.
REQ-030 Latency SHALL be zero cycles (combinational forward path); throughput one flit per cycle, no bubble at header/payload or packet boundaries.
REQ-031 Upstream SHALL hold header_data, header_is_request, header_has_payload stable while header_valid is high and header_ready is low; packer SHALL not register header contents.
REQ-032 Downstream stall (flit_ready=0) SHALL hold state, flit_count and all flit outputs stable given stable inputs.
REQ-033 payload_valid while in HEADER SHALL be ignored (not consumed); header_valid while in PAYLOAD SHALL be ignored.
REQ-034 Single-flit packet (RESPONSE_HEADER_FLITS=1, no payload) SHALL emit one flit with flit_head=1 and flit_tail=1.

Reset
REQ-035 While rst=1: state = HEADER, flit_count = 0, and flit_valid, header_ready, payload_ready SHALL be forced 0 irrespective of inputs.
REQ-036 Reset asserted mid-packet SHALL abandon the packet; after release the next flit SHALL be header flit 0 with flit_head=1.

Verification
REQ-037 Request, has_payload=1, 2 header flits H0,H1 + 3 payload words, flit_ready=1 -> 5 flits on consecutive cycles: type 0,0,1,1,1; head 1,0,0,0,0; tail 0,0,0,0,1; header_ready high only with H1.
REQ-038 Response, has_payload=0, RESPONSE_HEADER_FLITS=1 -> single flit head=1 tail=1, header_ready in same cycle, next cycle accepts new header.
REQ-039 flit_ready held 0 for 3 cycles on H1 -> flit_data stays H1, flit_count stays 1, header_ready stays 0, then completes on ready.
REQ-040 Back-to-back: request with payload then response without payload, valids always high -> no idle cycle between payload_last and next header flit 0.
REQ-041 payload_valid=1 during HEADER -> payload_ready=0 and payload not emitted until header complete.
REQ-042 rst pulsed after H0 handshake -> outputs valid/ready 0 during reset; after release header flit 0 re-emitted with flit_head=1.
